// File: rtl/id_ex_pipe_reg_if.sv
// Bus between the ID stage, the ID/EX pipeline register and the EX stage.
// The master side is the ID/hazard control logic; the slave side is the pipeline register.
interface id_ex_pipe_reg_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             id_valid_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic [XLEN-1:0]  rs2_data_i;
  logic [XLEN-1:0]  iimm_i;
  logic [XLEN-1:0]  simm_i;
  logic [RA_W-1:0]  rs1_addr_i;
  logic [RA_W-1:0]  rs2_addr_i;
  logic [RA_W-1:0]  rd_addr_i;
  logic [2:0]       funct3_i;
  logic [6:0]       funct7_i;
  logic [1:0]       alu_op_i;
  logic             alu_src_i;
  logic [1:0]       mem_i;
  logic             wb_i;
  logic             stall_i;
  logic             flush_i;

  logic             ex_valid_o;
  logic [XLEN-1:0]  val1_o;
  logic [XLEN-1:0]  val2_o;
  logic [XLEN-1:0]  simm_o;
  logic [3:0]       alu_ctrl_o;
  logic             illegal_o;
  logic [RA_W-1:0]  rs1_addr_o;
  logic [RA_W-1:0]  rs2_addr_o;
  logic [RA_W-1:0]  rd_addr_o;
  logic [1:0]       mem_o;
  logic             wb_o;
  logic             load_use_stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output id_valid_i, rs1_data_i, rs2_data_i, iimm_i, simm_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_i,
           alu_op_i, alu_src_i, mem_i, wb_i, stall_i, flush_i,
    input  ex_valid_o, val1_o, val2_o, simm_o, alu_ctrl_o, illegal_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, mem_o, wb_o,
           load_use_stall_o, bubble_cnt_o
  );

  modport slave (
    input  id_valid_i, rs1_data_i, rs2_data_i, iimm_i, simm_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, funct3_i, funct7_i,
           alu_op_i, alu_src_i, mem_i, wb_i, stall_i, flush_i,
    output ex_valid_o, val1_o, val2_o, simm_o, alu_ctrl_o, illegal_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, mem_o, wb_o,
           load_use_stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: operand capture, ALU control decode, stall/flush handling,
// load-use bubble insertion and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  id_ex_pipe_reg_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
    logic [XLEN-1:0] simm;
    logic [3:0]      alu_ctrl;
    logic            illegal;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [1:0]      mem;
    logic            wb;
  } stage_t;

  stage_t           stage_q;
  stage_t           capture;
  logic [3:0]       alu_ctrl_d;
  logic             illegal_d;
  logic             load_use;
  logic [CNT_W-1:0] bubble_cnt;

  always_comb begin
    alu_ctrl_d = 4'b0010;
    illegal_d  = 1'b0;
    case (bus.alu_op_i)
      2'b00: alu_ctrl_d = 4'b0010;
      2'b01: alu_ctrl_d = 4'b0110;
      2'b10: begin
        case ({bus.funct7_i, bus.funct3_i})
          10'b0000000_000: alu_ctrl_d = 4'b0010;
          10'b0100000_000: alu_ctrl_d = 4'b0110;
          10'b0000000_111: alu_ctrl_d = 4'b0000;
          10'b0000000_110: alu_ctrl_d = 4'b0001;
          10'b0000001_000: alu_ctrl_d = 4'b1111;
          default:         illegal_d  = 1'b1;
        endcase
      end
      default: begin
        case (bus.funct3_i)
          3'b000:  alu_ctrl_d = 4'b0010;
          3'b111:  alu_ctrl_d = 4'b0000;
          3'b110:  alu_ctrl_d = 4'b0001;
          default: illegal_d  = 1'b1;
        endcase
      end
    endcase
    // An empty ID slot must never raise an illegal-instruction trap downstream.
    if (!bus.id_valid_i) illegal_d = 1'b0;
  end

  always_comb begin
    capture          = '0;
    capture.valid    = bus.id_valid_i;
    capture.val1     = bus.rs1_data_i;
    capture.val2     = bus.alu_src_i ? bus.iimm_i : bus.rs2_data_i;
    capture.simm     = bus.simm_i;
    capture.alu_ctrl = alu_ctrl_d;
    capture.illegal  = illegal_d;
    capture.rs1_addr = bus.rs1_addr_i;
    capture.rs2_addr = bus.rs2_addr_i;
    capture.rd_addr  = bus.rd_addr_i;
    capture.mem      = bus.id_valid_i ? bus.mem_i : 2'b00;
    capture.wb       = bus.id_valid_i & bus.wb_i;
  end

  // rs2 is compared even for I-type consumers since stores read rs2 as data.
  assign load_use = stage_q.valid & stage_q.mem[1] & (stage_q.rd_addr != '0) &
                    bus.id_valid_i &
                    ((stage_q.rd_addr == bus.rs1_addr_i) | (stage_q.rd_addr == bus.rs2_addr_i));

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i || (!bus.stall_i && load_use)) begin
      stage_q <= '0;
    end else if (!bus.stall_i) begin
      stage_q <= capture;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt <= '0;
    end else if (!bus.flush_i && !bus.stall_i && load_use && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign bus.ex_valid_o       = stage_q.valid;
  assign bus.val1_o           = stage_q.val1;
  assign bus.val2_o           = stage_q.val2;
  assign bus.simm_o           = stage_q.simm;
  assign bus.alu_ctrl_o       = stage_q.alu_ctrl;
  assign bus.illegal_o        = stage_q.illegal;
  assign bus.rs1_addr_o       = stage_q.rs1_addr;
  assign bus.rs2_addr_o       = stage_q.rs2_addr;
  assign bus.rd_addr_o        = stage_q.rd_addr;
  assign bus.mem_o            = stage_q.mem;
  assign bus.wb_o             = stage_q.wb;
  assign bus.load_use_stall_o = load_use;
  assign bus.bubble_cnt_o     = bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed scenarios plus random traffic against a
// behavioural model, with a second narrow-counter instance to exercise saturation.
module tb_id_ex_pipe_reg;

  logic clk_i;
  logic rst_i;

  id_ex_pipe_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.XLEN(32), .RA_W(5), .CNT_W(2))  sat_bus ();

  id_ex_pipe_reg #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  id_ex_pipe_reg #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_sat (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (sat_bus)
  );

  assign sat_bus.id_valid_i = bus.id_valid_i;
  assign sat_bus.rs1_data_i = bus.rs1_data_i;
  assign sat_bus.rs2_data_i = bus.rs2_data_i;
  assign sat_bus.iimm_i     = bus.iimm_i;
  assign sat_bus.simm_i     = bus.simm_i;
  assign sat_bus.rs1_addr_i = bus.rs1_addr_i;
  assign sat_bus.rs2_addr_i = bus.rs2_addr_i;
  assign sat_bus.rd_addr_i  = bus.rd_addr_i;
  assign sat_bus.funct3_i   = bus.funct3_i;
  assign sat_bus.funct7_i   = bus.funct7_i;
  assign sat_bus.alu_op_i   = bus.alu_op_i;
  assign sat_bus.alu_src_i  = bus.alu_src_i;
  assign sat_bus.mem_i      = bus.mem_i;
  assign sat_bus.wb_i       = bus.wb_i;
  assign sat_bus.stall_i    = bus.stall_i;
  assign sat_bus.flush_i    = bus.flush_i;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    bit          valid;
    logic [31:0] rs1d, rs2d, iimm, simm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  op;
    bit          src;
    logic [1:0]  mem;
    bit          wb;
    bit          stall;
    bit          flush;
  } stim_t;

  typedef struct {
    bit          valid;
    logic [31:0] val1, val2, simm;
    logic [3:0]  ctrl;
    bit          illegal;
    logic [4:0]  rs1a, rs2a, rda;
    logic [1:0]  mem;
    bit          wb;
  } state_t;

  typedef struct {
    bit          check_lus;
    bit          lus;
    state_t      st;
    int unsigned cnt;
  } exp_t;

  exp_t        exp_q[$];
  state_t      mdl;
  int unsigned mdl_cnt;
  bit          mdl_known;
  int          tests;
  int          failures;
  logic        lus_seen;
  logic        sat_lus_seen;
  exp_t        mon_e;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Decode from lookup tables of legal encodings rather than nested cases.
  function automatic void model_decode(input stim_t s, output logic [3:0] ctrl, output bit ill);
    logic [9:0] r_keys [5] = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_111,
                               10'b0000000_110, 10'b0000001_000};
    logic [3:0] r_codes [5] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd15};
    logic [2:0] i_keys [3] = '{3'b000, 3'b111, 3'b110};
    logic [3:0] i_codes [3] = '{4'd2, 4'd0, 4'd1};
    bit found = 0;
    ctrl = 4'd2;
    if (s.op == 2'd0) found = 1;
    else if (s.op == 2'd1) begin ctrl = 4'd6; found = 1; end
    else if (s.op == 2'd2) begin
      for (int k = 0; k < 5; k++)
        if (r_keys[k] == {s.f7, s.f3}) begin ctrl = r_codes[k]; found = 1; end
    end else begin
      for (int k = 0; k < 3; k++)
        if (i_keys[k] == s.f3) begin ctrl = i_codes[k]; found = 1; end
    end
    ill = !found && s.valid;
  endfunction

  function automatic bit model_lus(input stim_t s);
    return mdl.valid && mdl.mem[1] && (mdl.rda != 0) && s.valid &&
           ((mdl.rda == s.rs1a) || (mdl.rda == s.rs2a));
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst: 0, valid: 1, rs1d: 0, rs2d: 0, iimm: 0, simm: 0, rs1a: 0, rs2a: 0, rda: 0,
          f3: 0, f7: 0, op: 0, src: 0, mem: 0, wb: 0, stall: 0, flush: 0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [6:0] f7_pick [4];
    f7_pick = '{7'h00, 7'h20, 7'h01, 7'h00};
    f7_pick[3] = 7'($urandom);
    s.rst   = ($urandom_range(0, 49) == 0);
    s.valid = ($urandom_range(0, 9) != 0);
    s.rs1d  = $urandom; s.rs2d = $urandom; s.iimm = $urandom; s.simm = $urandom;
    s.rs1a  = 5'($urandom_range(0, 3));
    s.rs2a  = 5'($urandom_range(0, 3));
    s.rda   = 5'($urandom_range(0, 3));
    s.f3    = 3'($urandom);
    s.f7    = f7_pick[$urandom_range(0, 3)];
    s.op    = 2'($urandom);
    s.src   = 1'($urandom);
    s.mem   = 2'($urandom);
    s.wb    = 1'($urandom);
    s.stall = ($urandom_range(0, 6) == 0);
    s.flush = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Drives one cycle of ID inputs and queues what EX must look like after the next edge.
  task automatic apply_stimulus(input stim_t s);
    exp_t   e;
    state_t cap;
    logic [3:0] ctrl;
    bit     ill;
    @(negedge clk_i);
    rst_i          = s.rst;
    bus.id_valid_i = s.valid;
    bus.rs1_data_i = s.rs1d;
    bus.rs2_data_i = s.rs2d;
    bus.iimm_i     = s.iimm;
    bus.simm_i     = s.simm;
    bus.rs1_addr_i = s.rs1a;
    bus.rs2_addr_i = s.rs2a;
    bus.rd_addr_i  = s.rda;
    bus.funct3_i   = s.f3;
    bus.funct7_i   = s.f7;
    bus.alu_op_i   = s.op;
    bus.alu_src_i  = s.src;
    bus.mem_i      = s.mem;
    bus.wb_i       = s.wb;
    bus.stall_i    = s.stall;
    bus.flush_i    = s.flush;
    #1;
    e.check_lus = mdl_known;
    e.lus       = mdl_known && model_lus(s);
    model_decode(s, ctrl, ill);
    cap = '{valid: s.valid, val1: s.rs1d, val2: (s.src ? s.iimm : s.rs2d), simm: s.simm,
            ctrl: ctrl, illegal: ill, rs1a: s.rs1a, rs2a: s.rs2a, rda: s.rda,
            mem: (s.valid ? s.mem : 2'b00), wb: (s.valid && s.wb)};
    if (s.rst) begin
      mdl = '{default: 0}; mdl_cnt = 0; mdl_known = 1;
    end else if (s.flush) begin
      mdl = '{default: 0};
    end else if (s.stall) begin
      mdl = mdl;
    end else if (e.lus) begin
      mdl = '{default: 0}; mdl_cnt++;
    end else begin
      mdl = cap;
    end
    e.st  = mdl;
    e.cnt = mdl_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: samples the combinational stall mid-cycle, registered outputs just after the edge.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      lus_seen     = bus.load_use_stall_o;
      sat_lus_seen = sat_bus.load_use_stall_o;
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        if (mon_e.check_lus) begin
          check_output("load_use_stall", 64'(lus_seen), 64'(mon_e.lus));
          check_output("sat_load_use_stall", 64'(sat_lus_seen), 64'(mon_e.lus));
        end
        check_output("ex_valid", 64'(bus.ex_valid_o), 64'(mon_e.st.valid));
        check_output("val1", 64'(bus.val1_o), 64'(mon_e.st.val1));
        check_output("val2", 64'(bus.val2_o), 64'(mon_e.st.val2));
        check_output("simm", 64'(bus.simm_o), 64'(mon_e.st.simm));
        check_output("alu_ctrl", 64'(bus.alu_ctrl_o), 64'(mon_e.st.ctrl));
        check_output("illegal", 64'(bus.illegal_o), 64'(mon_e.st.illegal));
        check_output("rs1_addr", 64'(bus.rs1_addr_o), 64'(mon_e.st.rs1a));
        check_output("rs2_addr", 64'(bus.rs2_addr_o), 64'(mon_e.st.rs2a));
        check_output("rd_addr", 64'(bus.rd_addr_o), 64'(mon_e.st.rda));
        check_output("mem", 64'(bus.mem_o), 64'(mon_e.st.mem));
        check_output("wb", 64'(bus.wb_o), 64'(mon_e.st.wb));
        check_output("bubble_cnt", 64'(bus.bubble_cnt_o), 64'((mon_e.cnt > 65535) ? 65535 : mon_e.cnt));
        check_output("sat_bubble_cnt", 64'(sat_bus.bubble_cnt_o), 64'((mon_e.cnt > 3) ? 3 : mon_e.cnt));
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cycles;
    tests = 0; failures = 0; mdl_known = 0; mdl = '{default: 0}; mdl_cnt = 0;
    rst_i = 1'b1;
    s = idle_stim();
    s.rst = 1;
    bus.id_valid_i = 0; bus.rs1_data_i = 0; bus.rs2_data_i = 0; bus.iimm_i = 0; bus.simm_i = 0;
    bus.rs1_addr_i = 0; bus.rs2_addr_i = 0; bus.rd_addr_i = 0; bus.funct3_i = 0; bus.funct7_i = 0;
    bus.alu_op_i = 0; bus.alu_src_i = 0; bus.mem_i = 0; bus.wb_i = 0; bus.stall_i = 0; bus.flush_i = 0;

    // Reset held for two cycles with random inputs.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim();
      s.rst = 1;
      apply_stimulus(s);
    end
    @(posedge clk_i); #1;
    check_output("reset_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    check_output("reset_bubble_cnt", 64'(bus.bubble_cnt_o), 64'd0);

    // R-type sub.
    s = idle_stim();
    s.op = 2'b10; s.f7 = 7'b0100000; s.f3 = 3'b000; s.rs1d = 32'h10; s.rs2d = 32'h3;
    s.rs1a = 5'd1; s.rs2a = 5'd2; s.rda = 5'd7; s.wb = 1;
    apply_stimulus(s);
    @(posedge clk_i); #1;
    check_output("rtype_val1", 64'(bus.val1_o), 64'h10);
    check_output("rtype_val2", 64'(bus.val2_o), 64'h3);
    check_output("rtype_alu_ctrl", 64'(bus.alu_ctrl_o), 64'b0110);
    check_output("rtype_illegal", 64'(bus.illegal_o), 64'd0);

    // I-type andi, then an unsupported R-type encoding.
    s = idle_stim();
    s.op = 2'b11; s.f3 = 3'b111; s.iimm = 32'hFF; s.src = 1; s.rs2d = 32'h1234;
    apply_stimulus(s);
    @(posedge clk_i); #1;
    check_output("itype_val2", 64'(bus.val2_o), 64'hFF);
    check_output("itype_alu_ctrl", 64'(bus.alu_ctrl_o), 64'b0000);
    s = idle_stim();
    s.op = 2'b10; s.f3 = 3'b001;
    apply_stimulus(s);
    @(posedge clk_i); #1;
    check_output("illegal_alu_ctrl", 64'(bus.alu_ctrl_o), 64'b0010);
    check_output("illegal_flag", 64'(bus.illegal_o), 64'd1);

    // Load-use on rd=5, then the same pattern with rd=0.
    s = idle_stim();
    s.rda = 5'd5; s.mem = 2'b10; s.wb = 1; s.rs1a = 5'd1; s.rs2a = 5'd2;
    apply_stimulus(s);
    s = idle_stim();
    s.rs1a = 5'd5; s.rs2a = 5'd3; s.rda = 5'd6; s.wb = 1;
    apply_stimulus(s);
    @(posedge clk_i); #1;
    check_output("bubble_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    check_output("bubble_wb", 64'(bus.wb_o), 64'd0);
    check_output("bubble_cnt_one", 64'(bus.bubble_cnt_o), 64'd1);
    check_output("bubble_stall_drops", 64'(bus.load_use_stall_o), 64'd0);
    apply_stimulus(s);
    s = idle_stim();
    s.rda = 5'd0; s.mem = 2'b10; s.wb = 1;
    apply_stimulus(s);
    s = idle_stim();
    s.rs1a = 5'd0; s.rda = 5'd4;
    apply_stimulus(s);
    @(posedge clk_i); #1;
    check_output("rd0_no_bubble", 64'(bus.ex_valid_o), 64'd1);
    check_output("rd0_cnt_same", 64'(bus.bubble_cnt_o), 64'd1);

    // Three stalled cycles freeze the stage; stall with flush clears it.
    s = idle_stim();
    s.rs1d = 32'hCAFE0001; s.rda = 5'd9;
    apply_stimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim();
      s.rst = 0; s.flush = 0; s.stall = 1;
      apply_stimulus(s);
      @(posedge clk_i); #1;
      check_output("stall_hold_val1", 64'(bus.val1_o), 64'hCAFE0001);
    end
    s = rand_stim();
    s.rst = 0; s.stall = 1; s.flush = 1;
    apply_stimulus(s);
    @(posedge clk_i); #1;
    check_output("flush_ex_valid", 64'(bus.ex_valid_o), 64'd0);
    check_output("flush_val1", 64'(bus.val1_o), 64'd0);

    // Five bubbles on the 2-bit counter saturate at 3.
    s = idle_stim();
    s.rst = 1;
    apply_stimulus(s);
    for (int i = 1; i <= 5; i++) begin
      s = idle_stim();
      s.rda = 5'd5; s.mem = 2'b10; s.wb = 1;
      apply_stimulus(s);
      s = idle_stim();
      s.rs2a = 5'd5; s.rda = 5'd8;
      apply_stimulus(s);
      @(posedge clk_i); #1;
      check_output("sat_sequence", 64'(sat_bus.bubble_cnt_o), 64'((i > 3) ? 3 : i));
    end

    for (int i = 0; i < 400; i++) apply_stimulus(rand_stim());

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk_i);
      wait_cycles++;
    end
    #2;
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
